// File: rtl/pipe_share_arbiter.sv
// Round-robin sharing of one fixed-latency, non-stallable pipeline among NUM_PORTS requesters.
// A tag delay line tracks which port owns each beat so results can be routed back on return.
module pipe_share_arbiter #(
   parameter int NUM_PORTS  = 4,
   parameter int DATA_WIDTH = 32,
   parameter int LATENCY    = 2
) (
   input  logic                             clock,
   input  logic                             reset,
   input  logic [NUM_PORTS-1:0]             port_enable,
   input  logic [NUM_PORTS*DATA_WIDTH-1:0]  s_pipe_tdata,
   input  logic [NUM_PORTS-1:0]             s_pipe_tvalid,
   output logic [NUM_PORTS-1:0]             s_pipe_tready,
   output logic [DATA_WIDTH-1:0]            p_pipe_tdata,
   output logic                             p_pipe_tvalid,
   input  logic [DATA_WIDTH-1:0]            r_pipe_tdata,
   input  logic                             r_pipe_tvalid,
   output logic [NUM_PORTS*DATA_WIDTH-1:0]  m_pipe_tdata,
   output logic [NUM_PORTS-1:0]             m_pipe_tvalid,
   output logic                             error
);

   localparam int IDX_W = $clog2(NUM_PORTS);

   logic [IDX_W-1:0]      rr_q, rr_d;
   logic [NUM_PORTS-1:0]  grant;
   logic [IDX_W-1:0]      gidx;
   logic                  gvld;

   logic                  pvld_q;
   logic [DATA_WIDTH-1:0] pdata_q;
   logic [IDX_W-1:0]      pport_q;
   logic                  error_q;

   logic                  exp_valid;
   logic [IDX_W-1:0]      exp_port;

   // Grant: first enabled, valid port at or after the round-robin pointer.
   always_comb begin
      int               idx;
      logic [IDX_W-1:0] sel;
      idx   = 0;
      sel   = '0;
      grant = '0;
      gidx  = '0;
      gvld  = 1'b0;
      rr_d  = rr_q;
      if (!reset) begin
         for (int k = 0; k < NUM_PORTS; k++) begin
            idx = (int'(rr_q) + k) % NUM_PORTS;
            sel = IDX_W'(idx);
            if (!gvld && s_pipe_tvalid[sel] && port_enable[sel]) begin
               gvld = 1'b1;
               gidx = sel;
            end
         end
      end
      if (gvld) begin
         grant[gidx] = 1'b1;
         rr_d = (gidx == IDX_W'(NUM_PORTS - 1)) ? '0 : gidx + IDX_W'(1);
      end
   end

   assign s_pipe_tready = grant;

   // Pipeline input register stage; data and owner index carry no reset.
   always_ff @(posedge clock) begin
      if (reset) begin
         rr_q    <= '0;
         pvld_q  <= 1'b0;
         error_q <= 1'b0;
      end else begin
         rr_q   <= rr_d;
         pvld_q <= gvld;
         if (r_pipe_tvalid != exp_valid) error_q <= 1'b1;
      end
      pdata_q <= s_pipe_tdata[gidx*DATA_WIDTH +: DATA_WIDTH];
      pport_q <= gidx;
   end

   assign p_pipe_tvalid = pvld_q;
   assign p_pipe_tdata  = pdata_q;
   assign error         = error_q;

   // Tag line mirrors the external pipeline depth so exp_* lines up with r_pipe.
   generate
      if (LATENCY == 0) begin : g_tag_wire
         assign exp_valid = pvld_q;
         assign exp_port  = pport_q;
      end else begin : g_tag_line
         logic             tvld_q  [LATENCY];
         logic [IDX_W-1:0] tport_q [LATENCY];

         always_ff @(posedge clock) begin
            if (reset) begin
               for (int s = 0; s < LATENCY; s++) tvld_q[s] <= 1'b0;
            end else begin
               tvld_q[0] <= pvld_q;
               for (int s = 1; s < LATENCY; s++) tvld_q[s] <= tvld_q[s-1];
            end
            tport_q[0] <= pport_q;
            for (int s = 1; s < LATENCY; s++) tport_q[s] <= tport_q[s-1];
         end

         assign exp_valid = tvld_q[LATENCY-1];
         assign exp_port  = tport_q[LATENCY-1];
      end
   endgenerate

   // Untagged returning beats are dropped here; the error flag records them.
   always_comb begin
      m_pipe_tvalid = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         m_pipe_tvalid[i] = r_pipe_tvalid & exp_valid & (exp_port == IDX_W'(i));
      end
   end

   assign m_pipe_tdata = {NUM_PORTS{r_pipe_tdata}};

endmodule

// File: tb/tb_pipe_share_arbiter.sv
// Randomized and directed bench for pipe_share_arbiter against a queue-based reference model.
// A two-stage delay stands in for the shared pipeline and shares the DUT reset.
module tb_pipe_share_arbiter;
   localparam int NP  = 4;
   localparam int DW  = 32;
   localparam int LAT = 2;

   logic                clock = 1'b0;
   logic                reset;
   logic [NP-1:0]       port_enable;
   logic [NP*DW-1:0]    s_pipe_tdata;
   logic [NP-1:0]       s_pipe_tvalid;
   logic [NP-1:0]       s_pipe_tready;
   logic [DW-1:0]       p_pipe_tdata;
   logic                p_pipe_tvalid;
   logic [DW-1:0]       r_pipe_tdata;
   logic                r_pipe_tvalid;
   logic [NP*DW-1:0]    m_pipe_tdata;
   logic [NP-1:0]       m_pipe_tvalid;
   logic                error;
   logic                inject;

   logic                pv0_q, pv1_q;
   logic [DW-1:0]       pd0_q, pd1_q;

   pipe_share_arbiter #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .LATENCY(LAT)) dut (
      .clock(clock), .reset(reset), .port_enable(port_enable),
      .s_pipe_tdata(s_pipe_tdata), .s_pipe_tvalid(s_pipe_tvalid), .s_pipe_tready(s_pipe_tready),
      .p_pipe_tdata(p_pipe_tdata), .p_pipe_tvalid(p_pipe_tvalid),
      .r_pipe_tdata(r_pipe_tdata), .r_pipe_tvalid(r_pipe_tvalid),
      .m_pipe_tdata(m_pipe_tdata), .m_pipe_tvalid(m_pipe_tvalid), .error(error)
   );

   always #5 clock = ~clock;

   // External two-stage pipeline, reset together with the DUT.
   always_ff @(posedge clock) begin
      if (reset) begin
         pv0_q <= 1'b0;
         pv1_q <= 1'b0;
      end else begin
         pv0_q <= p_pipe_tvalid;
         pv1_q <= pv0_q;
      end
      pd0_q <= p_pipe_tdata;
      pd1_q <= pd0_q;
   end

   assign r_pipe_tvalid = pv1_q | inject;
   assign r_pipe_tdata  = pd1_q;

   typedef struct {
      int            due;
      int            port;
      logic [DW-1:0] data;
   } beat_t;

   beat_t         q[$];
   int            cyc = 0;
   int            mrr = 0;
   bit            m_last_vld = 1'b0;
   logic [DW-1:0] m_last_data = '0;
   bit            m_err = 1'b0;

   logic [NP-1:0] e_ready, e_mvld;
   logic [DW-1:0] e_mdata, e_pdata;
   logic          e_pvld, e_err;
   int            e_port;

   int compared   = 0;
   int mismatched = 0;

   // Reference model: evaluates one cycle from the currently applied inputs.
   task automatic model_eval();
      int            g;
      bit            due_hit;
      logic [NP-1:0] cand;
      beat_t         b;
      e_pvld  = m_last_vld;
      e_pdata = m_last_data;
      e_err   = m_err;
      e_mvld  = '0;
      e_mdata = '0;
      e_port  = 0;
      due_hit = 1'b0;
      if (q.size() > 0 && q[0].due == cyc) begin
         b = q.pop_front();
         due_hit = 1'b1;
         e_mvld[b.port] = 1'b1;
         e_mdata = b.data;
         e_port  = b.port;
      end
      e_ready = '0;
      g = -1;
      cand = s_pipe_tvalid & port_enable;
      if (!reset) begin
         for (int k = 0; k < NP; k++) begin
            if (g < 0 && cand[(mrr + k) % NP]) g = (mrr + k) % NP;
         end
      end
      m_last_vld = (g >= 0);
      if (g >= 0) begin
         e_ready[g] = 1'b1;
         m_last_data = s_pipe_tdata[g*DW +: DW];
         q.push_back('{due: cyc + 1 + LAT, port: g, data: s_pipe_tdata[g*DW +: DW]});
         mrr = (g + 1) % NP;
      end
      if (inject && !due_hit) m_err = 1'b1;
      if (reset) begin
         q.delete();
         mrr = 0;
         m_last_vld = 1'b0;
         m_err = 1'b0;
      end
      cyc++;
   endtask

   task automatic drive(input logic [NP-1:0] v, input logic [NP-1:0] en, input logic inj);
      s_pipe_tvalid = v;
      port_enable   = en;
      inject        = inj;
      for (int i = 0; i < NP; i++) s_pipe_tdata[i*DW +: DW] = $urandom;
   endtask

   task automatic sample();
      @(negedge clock);
      model_eval();
   endtask

   task automatic advance();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      drive('0, '1, 1'b0);
      sample();
      advance();
      sample();
      compared++; if (s_pipe_tready !== 4'b0000) begin mismatched++; $display("FAIL reset_ready: got %b required 0000", s_pipe_tready); end
      compared++; if (p_pipe_tvalid !== 1'b0) begin mismatched++; $display("FAIL reset_pvld: got %b required 0", p_pipe_tvalid); end
      compared++; if (m_pipe_tvalid !== 4'b0000) begin mismatched++; $display("FAIL reset_mvld: got %b required 0000", m_pipe_tvalid); end
      compared++; if (error !== 1'b0) begin mismatched++; $display("FAIL reset_error: got %b required 0", error); end
      advance();
      reset = 1'b0;
      drive('0, '1, 1'b0);
      sample();
      compared++; if (s_pipe_tready !== 4'b0000) begin mismatched++; $display("FAIL idle_ready: got %b required 0000", s_pipe_tready); end
      compared++; if (p_pipe_tvalid !== 1'b0) begin mismatched++; $display("FAIL idle_pvld: got %b required 0", p_pipe_tvalid); end
      advance();
   endtask

   task automatic test_all_ports();
      for (int n = 0; n < 16; n++) begin
         drive(4'b1111, 4'b1111, 1'b0);
         sample();
         compared++; if (s_pipe_tready !== e_ready) begin mismatched++; $display("FAIL all_ready c%0d: got %b required %b", cyc, s_pipe_tready, e_ready); end
         compared++; if (p_pipe_tvalid !== e_pvld) begin mismatched++; $display("FAIL all_pvld c%0d: got %b required %b", cyc, p_pipe_tvalid, e_pvld); end
         if (e_pvld) begin compared++; if (p_pipe_tdata !== e_pdata) begin mismatched++; $display("FAIL all_pdata c%0d: got %h required %h", cyc, p_pipe_tdata, e_pdata); end end
         compared++; if (m_pipe_tvalid !== e_mvld) begin mismatched++; $display("FAIL all_mvld c%0d: got %b required %b", cyc, m_pipe_tvalid, e_mvld); end
         if (e_mvld != '0) begin compared++; if (m_pipe_tdata[e_port*DW +: DW] !== e_mdata) begin mismatched++; $display("FAIL all_mdata c%0d: got %h required %h", cyc, m_pipe_tdata[e_port*DW +: DW], e_mdata); end end
         advance();
      end
   endtask

   task automatic test_single_port();
      logic [DW-1:0] vals [3];
      vals[0] = 32'h11; vals[1] = 32'h22; vals[2] = 32'h33;
      for (int n = 0; n < 8; n++) begin
         drive((n < 3) ? 4'b0100 : 4'b0000, 4'b1111, 1'b0);
         if (n < 3) s_pipe_tdata[2*DW +: DW] = vals[n];
         sample();
         if (n < 3) begin compared++; if (s_pipe_tready !== 4'b0100) begin mismatched++; $display("FAIL single_ready n%0d: got %b required 0100", n, s_pipe_tready); end end
         compared++; if (m_pipe_tvalid !== e_mvld) begin mismatched++; $display("FAIL single_mvld c%0d: got %b required %b", cyc, m_pipe_tvalid, e_mvld); end
         if (e_mvld != '0) begin compared++; if (m_pipe_tdata[e_port*DW +: DW] !== e_mdata) begin mismatched++; $display("FAIL single_mdata c%0d: got %h required %h", cyc, m_pipe_tdata[e_port*DW +: DW], e_mdata); end end
         advance();
      end
   endtask

   task automatic test_enable_mask();
      for (int n = 0; n < 10; n++) begin
         drive(4'b1111, 4'b1010, 1'b0);
         sample();
         compared++; if (s_pipe_tready !== e_ready) begin mismatched++; $display("FAIL mask_ready c%0d: got %b required %b", cyc, s_pipe_tready, e_ready); end
         compared++; if ((s_pipe_tready & 4'b0101) !== 4'b0000) begin mismatched++; $display("FAIL mask_disabled c%0d: got %b required 0000", cyc, s_pipe_tready & 4'b0101); end
         compared++; if (m_pipe_tvalid !== e_mvld) begin mismatched++; $display("FAIL mask_mvld c%0d: got %b required %b", cyc, m_pipe_tvalid, e_mvld); end
         if (e_mvld != '0) begin compared++; if (m_pipe_tdata[e_port*DW +: DW] !== e_mdata) begin mismatched++; $display("FAIL mask_mdata c%0d: got %h required %h", cyc, m_pipe_tdata[e_port*DW +: DW], e_mdata); end end
         advance();
      end
   endtask

   task automatic test_spurious();
      for (int n = 0; n < 9; n++) begin
         drive('0, 4'b1111, (n == 5) ? 1'b1 : 1'b0);
         sample();
         compared++; if (m_pipe_tvalid !== e_mvld) begin mismatched++; $display("FAIL spur_mvld c%0d: got %b required %b", cyc, m_pipe_tvalid, e_mvld); end
         compared++; if (error !== e_err) begin mismatched++; $display("FAIL spur_error c%0d: got %b required %b", cyc, error, e_err); end
         if (n > 5) begin compared++; if (error !== 1'b1) begin mismatched++; $display("FAIL spur_sticky n%0d: got %b required 1", n, error); end end
         advance();
      end
      inject = 1'b0;
   endtask

   task automatic test_reset_midflight();
      for (int n = 0; n < 2; n++) begin
         drive(4'b0010, 4'b1111, 1'b0);
         sample();
         compared++; if (s_pipe_tready !== 4'b0010) begin mismatched++; $display("FAIL mid_ready n%0d: got %b required 0010", n, s_pipe_tready); end
         advance();
      end
      reset = 1'b1;
      drive('0, 4'b1111, 1'b0);
      sample();
      advance();
      reset = 1'b0;
      for (int n = 0; n < 4; n++) begin
         drive('0, 4'b1111, 1'b0);
         sample();
         compared++; if (m_pipe_tvalid !== 4'b0000) begin mismatched++; $display("FAIL mid_mvld n%0d: got %b required 0000", n, m_pipe_tvalid); end
         compared++; if (error !== 1'b0) begin mismatched++; $display("FAIL mid_error n%0d: got %b required 0", n, error); end
         advance();
      end
      drive(4'b1111, 4'b1111, 1'b0);
      sample();
      compared++; if (s_pipe_tready !== 4'b0001) begin mismatched++; $display("FAIL mid_restart: got %b required 0001", s_pipe_tready); end
      advance();
   endtask

   task automatic test_random();
      logic [NP-1:0] en;
      for (int n = 0; n < 400; n++) begin
         en = ($urandom_range(0, 3) == 0) ? NP'($urandom_range(0, 15)) : 4'b1111;
         drive(NP'($urandom_range(0, 15)), en, 1'b0);
         sample();
         compared++; if (s_pipe_tready !== e_ready) begin mismatched++; $display("FAIL rnd_ready c%0d: got %b required %b", cyc, s_pipe_tready, e_ready); end
         compared++; if (p_pipe_tvalid !== e_pvld) begin mismatched++; $display("FAIL rnd_pvld c%0d: got %b required %b", cyc, p_pipe_tvalid, e_pvld); end
         if (e_pvld) begin compared++; if (p_pipe_tdata !== e_pdata) begin mismatched++; $display("FAIL rnd_pdata c%0d: got %h required %h", cyc, p_pipe_tdata, e_pdata); end end
         compared++; if (m_pipe_tvalid !== e_mvld) begin mismatched++; $display("FAIL rnd_mvld c%0d: got %b required %b", cyc, m_pipe_tvalid, e_mvld); end
         if (e_mvld != '0) begin compared++; if (m_pipe_tdata[e_port*DW +: DW] !== e_mdata) begin mismatched++; $display("FAIL rnd_mdata c%0d: got %h required %h", cyc, m_pipe_tdata[e_port*DW +: DW], e_mdata); end end
         compared++; if (error !== e_err) begin mismatched++; $display("FAIL rnd_error c%0d: got %b required %b", cyc, error, e_err); end
         advance();
      end
   endtask

   initial begin
      reset         = 1'b1;
      inject        = 1'b0;
      s_pipe_tvalid = '0;
      port_enable   = '1;
      s_pipe_tdata  = '0;
      test_reset();
      test_all_ports();
      test_single_port();
      test_enable_mask();
      test_spurious();
      test_reset_midflight();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
